// File: rtl/inst_mem_pkg.sv
// Shared types and default constants for the loadable instruction memory
// and its fetch front end.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [7:0] FILL_DEFAULT    = 8'hFF;
  localparam logic [7:0] HALT_OP_DEFAULT = 8'b1000_1000;

endpackage

// File: rtl/inst_mem_fetch_if.sv
// Load port plus valid/ready fetch handshake between the PC stage and the
// instruction memory; slave is the memory side, master the core/loader side.
interface inst_mem_fetch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic              load_en_i;
  logic [ADDR_W-1:0] load_addr_i;
  logic [DATA_W-1:0] load_data_i;
  logic              start_i;
  logic              load_mode_i;
  logic              fetch_req_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              fetch_ready_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              halted_o;
  logic              load_err_o;

  modport slave (
    input  load_en_i, load_addr_i, load_data_i, start_i, load_mode_i,
           fetch_req_i, fetch_addr_i, inst_ready_i,
    output fetch_ready_o, inst_valid_o, inst_o, inst_addr_o, halted_o,
           load_err_o
  );

  modport master (
    output load_en_i, load_addr_i, load_data_i, start_i, load_mode_i,
           fetch_req_i, fetch_addr_i, inst_ready_i,
    input  fetch_ready_o, inst_valid_o, inst_o, inst_addr_o, halted_o,
           load_err_o
  );

endinterface

// File: rtl/inst_mem_array.sv
// DEPTH x DATA_W storage with per-word written bits; the registered read port
// returns FILL for unwritten or unimplemented addresses.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(FILL_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_written;
  logic [DATA_W-1:0] r_rdata;

  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;
  logic              w_wr_hit;
  logic              w_rd_hit;

  assign w_widx   = i_waddr[IDX_W-1:0];
  assign w_ridx   = i_raddr[IDX_W-1:0];
  assign w_wr_hit = i_we && ({1'b0, i_waddr} < DEPTH_LIM);
  assign w_rd_hit = ({1'b0, i_raddr} < DEPTH_LIM) && r_written[w_ridx];

  // Storage itself is never reset; only the written bits gate what is visible.
  always_ff @(posedge i_clk) begin
    if (w_wr_hit) begin
      r_mem[w_widx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_written <= '0;
    end else if (w_wr_hit) begin
      r_written[w_widx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdata <= FILL;
    end else if (i_re) begin
      r_rdata <= w_rd_hit ? r_mem[w_ridx] : FILL;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction memory front end: LOAD/RUN/HALT mode FSM, one-entry fetch
// output register and the sticky load-error flag around inst_mem_array.
module inst_mem_fetch
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 8,
  parameter int                DEPTH   = 256,
  parameter logic [DATA_W-1:0] FILL    = DATA_W'(FILL_DEFAULT),
  parameter logic [DATA_W-1:0] HALT_OP = DATA_W'(HALT_OP_DEFAULT)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  inst_mem_fetch_if.slave bus
);

  state_t            r_state;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_halted;
  logic              r_load_err;

  logic              w_fetch_ready;
  logic              w_accept;
  logic              w_halt_hit;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;

  assign w_fetch_ready = (r_state == ST_RUN) && (!r_valid || bus.inst_ready_i);
  assign w_accept      = bus.fetch_req_i && w_fetch_ready;
  assign w_halt_hit    = (r_state == ST_RUN) && r_valid && bus.inst_ready_i &&
                         (w_rdata == HALT_OP);
  assign w_we          = bus.load_en_i && (r_state == ST_LOAD);
  // A fetch accepted alongside the HALT handoff is dropped, so inst_o keeps HALT_OP.
  assign w_re          = w_accept && !w_halt_hit;

  inst_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .FILL   (FILL)
  ) u_array (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_we    (w_we),
    .i_waddr (bus.load_addr_i),
    .i_wdata (bus.load_data_i),
    .i_re    (w_re),
    .i_raddr (bus.fetch_addr_i),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_LOAD;
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_halted   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      if (bus.load_en_i && (r_state != ST_LOAD)) begin
        r_load_err <= 1'b1;
      end
      unique case (r_state)
        ST_LOAD: begin
          if (bus.start_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_halt_hit) begin
            r_state  <= ST_HALT;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
          end else if (w_accept) begin
            r_valid <= 1'b1;
            r_addr  <= bus.fetch_addr_i;
          end else if (r_valid && bus.inst_ready_i) begin
            r_valid <= 1'b0;
          end
        end
        ST_HALT: begin
          if (bus.load_mode_i) begin
            r_state  <= ST_LOAD;
            r_halted <= 1'b0;
          end else if (bus.start_i) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign bus.fetch_ready_o = w_fetch_ready;
  assign bus.inst_valid_o  = r_valid;
  assign bus.inst_o        = w_rdata;
  assign bus.inst_addr_o   = r_addr;
  assign bus.halted_o      = r_halted;
  assign bus.load_err_o    = r_load_err;

endmodule
